// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared widths, state encoding and one-hot helper for the strobe decoder
package decoder_pkg;

    localparam int IN_W_DEF   = 4;
    localparam int OUT_W_DEF  = 16;
    localparam int HOLD_W_DEF = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [OUT_W_DEF-1:0] onehot(input logic [IN_W_DEF-1:0] code);
        logic [OUT_W_DEF-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_hold_cnt.sv
// rtl/decoder_hold_cnt.sv - load/decrement strobe-length counter; last marks the final held cycle
module decoder_hold_cnt #(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    output logic              last
);

    logic [HOLD_W-1:0] cnt;

    // Decrement stops at 1 so the counter can never wrap; the owner clears it on exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt > HOLD_W'(1)) begin
            cnt <= cnt - HOLD_W'(1);
        end
    end

    assign last = (cnt == HOLD_W'(1));

endmodule

// File: rtl/decoder_strobe.sv
// rtl/decoder_strobe.sv - registered 4-to-16 one-hot strobe decoder with hold length; DECODER_PARITY_EN adds parity check
module decoder_strobe
    import decoder_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_code,
    input  logic [HOLD_W-1:0] in_hold,
`ifdef DECODER_PARITY_EN
    input  logic              in_parity,
    output logic              err,
`endif
    output logic [OUT_W-1:0]  out,
    output logic              busy
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_HOLD = HOLD;

    logic [0:0]        state;
    logic              last;
    logic              accept;
    logic              code_ok;
    logic              start;
    logic              finish;
    logic [HOLD_W-1:0] load_val;

    assign in_ready = !reset && enable &&
                      (state == S_IDLE || (state == S_HOLD && last));
    assign accept   = in_valid && in_ready;

`ifdef DECODER_PARITY_EN
    assign code_ok = ~^{in_code, in_parity};
`else
    assign code_ok = 1'b1;
`endif

    assign start    = accept && code_ok;
    // A rejected beat in the last held cycle still lets the current strobe end normally.
    assign finish   = (state == S_HOLD) && last && !start;
    assign load_val = (in_hold == '0) ? HOLD_W'(1) : in_hold;

    decoder_hold_cnt #(
        .HOLD_W (HOLD_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (!enable || finish),
        .load     (start),
        .load_val (load_val),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state <= S_IDLE;
            out   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            state <= S_HOLD;
            out   <= OUT_W'(onehot(IN_W_DEF'(in_code)));
            busy  <= 1'b1;
        end else if (finish) begin
            state <= S_IDLE;
            out   <= '0;
            busy  <= 1'b0;
        end
    end

`ifdef DECODER_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            err <= 1'b0;
        end else begin
            err <= accept && !code_ok;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_strobe.sv
// tb/tb_decoder_strobe.sv - scoreboard bench for decoder_strobe; parity cases under DECODER_PARITY_EN
module tb_decoder_strobe;

    typedef struct {
        logic [15:0] val;
        int          len;
        int          start;
    } strobe_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic [7:0]  in_hold;
    logic        in_parity;
    logic        err_w;
    logic [15:0] out;
    logic        busy;

    int errors  = 0;
    int checks  = 0;
    int cyc_pos = 0;
    int err_exp = 0;
    int err_seen = 0;

    strobe_t     exp_q[$];
    logic [15:0] cur_val = '0;
    int          cur_len = 0;
    int          cur_start = 0;

    decoder_strobe dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_hold   (in_hold),
`ifdef DECODER_PARITY_EN
        .in_parity (in_parity),
        .err       (err_w),
`endif
        .out       (out),
        .busy      (busy)
    );

`ifndef DECODER_PARITY_EN
    assign err_w = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc_pos <= cyc_pos + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finalize();
        strobe_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: got val %h len %0d start %0d expected none",
                     cur_val, cur_len, cur_start);
        end else begin
            e = exp_q.pop_front();
            if (e.val !== cur_val || e.len != cur_len || e.start != cur_start) begin
                errors++;
                $display("FAIL strobe: got val %h len %0d start %0d expected val %h len %0d start %0d",
                         cur_val, cur_len, cur_start, e.val, e.len, e.start);
            end
        end
    endtask

    // Monitor: segments out into strobes and checks each against the scoreboard.
    always @(negedge clk) begin
        if (!reset || cur_val != 0) begin
            checks++;
            if ($countones(out) > 1 || busy !== (out != 16'h0)) begin
                errors++;
                $display("FAIL onehot_busy: got out %h busy %b expected one-hot with busy=(out!=0)",
                         out, busy);
            end
        end
        if (out !== cur_val) begin
            if (cur_val != 16'h0) finalize();
            if (out != 16'h0 && !$isunknown(out)) begin
                cur_val   = out;
                cur_start = cyc_pos;
                cur_len   = 1;
            end else begin
                cur_val = '0;
            end
        end else if (cur_val != 16'h0) begin
            cur_len++;
        end
        if (err_w === 1'b1) err_seen++;
    end

    // Called just after a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [3:0] code, input logic [7:0] hold, input logic par,
                        input logic [15:0] val, input int exp_len, input bit good);
        int n = 0;
        strobe_t e;
        in_valid  = 1'b1;
        in_code   = code;
        in_hold   = hold;
        in_parity = par;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got in_ready %b expected 1 within 100 cycles", in_ready);
        end
        if (good) begin
            e.val   = val;
            e.len   = exp_len;
            e.start = cyc_pos + 1;
            exp_q.push_back(e);
        end else begin
            err_exp++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_code  = 4'hA;
        in_hold  = 8'hFF;
    endtask

    task automatic basic_strobe();
        send(4'd5, 8'd3, 1'b0, 16'h0020, 3, 1'b1);
        chk("t2_ready_h1", in_ready, 0);
        @(negedge clk);
        chk("t2_ready_h2", in_ready, 0);
        @(negedge clk);
        chk("t2_ready_h3", in_ready, 1);
        chk("t2_out_h3", out, 32'h0020);
        @(negedge clk);
        chk("t2_out_after", out, 0);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b1;
        in_code   = 4'd6;
        in_hold   = 8'd2;
        in_parity = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out", out, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", in_ready, 0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);
        @(negedge clk);

        basic_strobe();
        repeat (2) @(negedge clk);

        send(4'd0, 8'd0, 1'b0, 16'h0001, 1, 1'b1);
        chk("t3_ready_last", in_ready, 1);
        send(4'd15, 8'd2, 1'b0, 16'h8000, 2, 1'b1);
        chk("t3_out_b2b", out, 32'h8000);
        repeat (3) @(negedge clk);

        send(4'd9, 8'd10, 1'b0, 16'h0200, 4, 1'b1);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("t4_out_abort", out, 0);
        chk("t4_busy_abort", busy, 0);
        chk("t4_ready_dis", in_ready, 0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_out_noresume", out, 0);
        chk("t4_ready_reen", in_ready, 1);

        send(4'd3, 8'd8, 1'b0, 16'h0008, 3, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_out_rst", out, 0);
        chk("t5_busy_rst", busy, 0);
        chk("t5_cnt_rst", dut.u_cnt.cnt, 0);
        chk("t5_ready_rst", in_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        basic_strobe();
        repeat (2) @(negedge clk);

`ifdef DECODER_PARITY_EN
        send(4'b0111, 8'd4, 1'b0, 16'h0000, 0, 1'b0);
        chk("t6_err_pulse", err_w, 1);
        chk("t6_out_bad", out, 0);
        @(negedge clk);
        chk("t6_err_clear", err_w, 0);
        send(4'b0111, 8'd1, 1'b1, 16'h0080, 1, 1'b1);
        chk("t6_out_good", out, 32'h0080);
        chk("t6_err_good", err_w, 0);
        repeat (2) @(negedge clk);
        send(4'd2, 8'd2, 1'b1, 16'h0004, 2, 1'b1);
        @(negedge clk);
        send(4'd4, 8'd5, 1'b0, 16'h0000, 0, 1'b0);
        chk("t6_err_last", err_w, 1);
        chk("t6_out_end", out, 0);
        chk("t6_busy_end", busy, 0);
        repeat (2) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("err_pulses", err_seen, err_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
